// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the handshaked ALU responder:
//   - ALU_W     : default operand width (results are 2*ALU_W wide)
//   - OP_*      : 3-bit opcode encoding
//   - state_t   : control FSM state encoding (IDLE, MUL, RESP)
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_W = 4;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_SHL = 3'd6;
  localparam logic [2:0] OP_LTU = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// ---------------------------------------------------------------------------
// alu_mul_iter
// Iterative unsigned shift-add multiplier, one partial-product step per cycle.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : load a/b and begin (pulse, one cycle)
//   a, b          : W-bit unsigned operands
//   done          : high during the final step cycle
//   product       : 2W-bit result, valid while done is high
// A start loads operands; the next ITER cycles each perform one step. done is
// asserted combinationally in the last step so the caller can register the
// final product on the same edge that retires the step.
// ---------------------------------------------------------------------------
module alu_mul_iter #(
  parameter int W    = 4,
  parameter int ITER = W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;

  logic [2*W-1:0] acc_reg;
  logic [2*W-1:0] mcand_reg;
  logic [W-1:0]   mplier_reg;
  logic [CW-1:0]  cnt_reg;
  logic           busy_reg;
  logic [2*W-1:0] acc_next;

  // Add the shifted multiplicand when the current multiplier LSB is set.
  assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
  assign done     = busy_reg && (cnt_reg == CW'(ITER - 1));
  assign product  = acc_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
    end else if (start) begin
      acc_reg    <= '0;
      mcand_reg  <= {{W{1'b0}}, a};
      mplier_reg <= b;
      cnt_reg    <= '0;
      busy_reg   <= 1'b1;
    end else if (busy_reg) begin
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_reg >> 1;
      cnt_reg    <= cnt_reg + CW'(1);
      if (done) begin
        busy_reg <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_handshake_unit.sv
// ---------------------------------------------------------------------------
// alu_handshake_unit
// Synchronous ALU responder: accepts one {a, b, sel} request over a
// valid/ready handshake and returns the 2W-bit result over a second
// valid/ready handshake. MUL is iterative (W extra cycles); all other ops
// respond the cycle after acceptance.
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   req_valid/req_ready        : request handshake
//   req_a, req_b, req_sel      : operands and opcode
//   resp_valid/resp_ready      : response handshake
//   resp_out, resp_sel         : result and echoed opcode
//   resp_zero, resp_carry      : result flags (only with ALU_FLAGS_EN defined)
// Optional feature macro: ALU_FLAGS_EN
// ---------------------------------------------------------------------------
module alu_handshake_unit
  import alu_pkg::*;
#(
  parameter int W = ALU_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [W-1:0]   req_a,
  input  logic [W-1:0]   req_b,
  input  logic [2:0]     req_sel,
  output logic           resp_valid,
  input  logic           resp_ready,
  output logic [2*W-1:0] resp_out,
  output logic [2:0]     resp_sel
`ifdef ALU_FLAGS_EN
  ,
  output logic           resp_zero,
  output logic           resp_carry
`endif
);

  localparam int MUL_ITER = W;

  state_t         state_reg;
  state_t         state_next;
  logic           accept;
  logic           mul_start;
  logic           mul_done;
  logic [2*W-1:0] mul_product;
  logic [2*W-1:0] a_ext;
  logic [2*W-1:0] b_ext;
  logic [2*W-1:0] sum;
  logic [2*W-1:0] alu_result;
  logic [2*W-1:0] resp_out_reg;
  logic [2:0]     resp_sel_reg;

  assign a_ext     = {{W{1'b0}}, req_a};
  assign b_ext     = {{W{1'b0}}, req_b};
  assign sum       = a_ext + b_ext;
  assign accept    = req_valid && req_ready;
  assign mul_start = accept && (req_sel == OP_MUL);

  alu_mul_iter #(
    .W    (W),
    .ITER (MUL_ITER)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (req_a),
    .b       (req_b),
    .done    (mul_done),
    .product (mul_product)
  );

  // Single-cycle opcodes; MUL is produced by the iterative multiplier.
  always_comb begin
    alu_result = '0;
    case (req_sel)
      OP_ADD:  alu_result = sum;
      OP_SUB:  alu_result = a_ext - b_ext;
      OP_AND:  alu_result = a_ext & b_ext;
      OP_OR:   alu_result = a_ext | b_ext;
      OP_XOR:  alu_result = a_ext ^ b_ext;
      OP_SHL:  alu_result = a_ext << req_b[2:0];
      OP_LTU:  alu_result = {{(2*W-1){1'b0}}, (req_a < req_b)};
      default: alu_result = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (accept) state_next = (req_sel == OP_MUL) ? MUL : RESP;
      MUL:     if (mul_done) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs. req_ready is gated by rst so nothing is accepted in a reset cycle.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state_reg)
      IDLE:    req_ready  = !rst;
      RESP:    resp_valid = 1'b1;
      default: ;
    endcase
  end

  // Result registers only load on accept or MUL completion, so they hold
  // steady for the whole RESP state regardless of resp_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_out_reg <= '0;
      resp_sel_reg <= '0;
    end else if (accept) begin
      resp_sel_reg <= req_sel;
      if (req_sel != OP_MUL) begin
        resp_out_reg <= alu_result;
      end
    end else if ((state_reg == MUL) && mul_done) begin
      resp_out_reg <= mul_product;
    end
  end

  assign resp_out = resp_out_reg;
  assign resp_sel = resp_sel_reg;

`ifdef ALU_FLAGS_EN
  logic zero_reg;
  logic carry_reg;
  logic carry_calc;

  // Carry out of the W-bit add, or borrow for subtract.
  assign carry_calc = (req_sel == OP_ADD) ? sum[W] :
                      (req_sel == OP_SUB) ? (req_a < req_b) : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      zero_reg  <= 1'b0;
      carry_reg <= 1'b0;
    end else if (accept && (req_sel != OP_MUL)) begin
      zero_reg  <= (alu_result == '0);
      carry_reg <= carry_calc;
    end else if ((state_reg == MUL) && mul_done) begin
      zero_reg  <= (mul_product == '0);
      carry_reg <= 1'b0;
    end
  end

  assign resp_zero  = zero_reg;
  assign resp_carry = carry_reg;
`endif

endmodule

// File: tb/tb_alu_handshake_unit.sv
// ---------------------------------------------------------------------------
// tb_alu_handshake_unit
// Self-checking bench for alu_handshake_unit: directed plan cases followed by
// randomized chained/stalled traffic, checked against an arithmetic model.
// Inputs change and outputs are sampled 1 time unit after the falling edge.
// Flag checks are active when ALU_FLAGS_EN is defined.
// ---------------------------------------------------------------------------
module tb_alu_handshake_unit;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_a;
  logic [3:0] req_b;
  logic [2:0] req_sel;
  logic       resp_valid;
  logic       resp_ready;
  logic [7:0] resp_out;
  logic [2:0] resp_sel;
`ifdef ALU_FLAGS_EN
  logic       resp_zero;
  logic       resp_carry;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned cyc = 0;
  int unsigned last_hs = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_handshake_unit #(.W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_sel    (req_sel),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_out   (resp_out),
    .resp_sel   (resp_sel)
`ifdef ALU_FLAGS_EN
    ,
    .resp_zero  (resp_zero),
    .resp_carry (resp_carry)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference arithmetic: plain integer math, reduced mod 256.
  function automatic logic [7:0] ref_alu(input int a, input int b, input int s);
    int r;
    case (s)
      0: r = a + b;
      1: r = a - b + 256;
      2: r = a * b;
      3: r = a & b;
      4: r = a | b;
      5: r = a ^ b;
      6: r = a * (1 << (b % 8));
      7: r = (a < b) ? 1 : 0;
      default: r = 0;
    endcase
    return 8'(r % 256);
  endfunction

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  // Issue one request and retire its response. Starts and ends at a sample
  // point (negedge + 1). chain_next leaves req_valid high with the next op's
  // operands; exp_b2b requires acceptance the cycle after the previous handshake.
  task automatic run_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] sel,
                        input int stall, input bit chain_next, input bit exp_b2b,
                        input logic [3:0] na, input logic [3:0] nb, input logic [2:0] nsel);
    int          n;
    int unsigned acc_cyc;
    int unsigned lat;
    logic [7:0]  exp;
    logic [7:0]  held_out;
    logic [2:0]  held_sel;
    exp = ref_alu(int'(a), int'(b), int'(sel));
    lat = (sel == OP_MUL) ? 5 : 1;
    req_valid = 1'b1; req_a = a; req_b = b; req_sel = sel;
    n = 0;
    while (!req_ready && n < 20) begin next_cycle(); n++; end
    check("req_ready", {31'b0, req_ready}, 32'd1);
    acc_cyc = cyc;
    if (exp_b2b) check("b2b_accept", acc_cyc, last_hs + 1);
    @(negedge clk);
    req_valid = chain_next; req_a = na; req_b = nb; req_sel = nsel;
    resp_ready = (stall == 0);
    #1;
    n = 0;
    while (!resp_valid && n < 20) begin
      check("busy_ready", {31'b0, req_ready}, 32'd0);
      next_cycle();
      n++;
    end
    check("resp_valid", {31'b0, resp_valid}, 32'd1);
    check("latency", cyc - acc_cyc, lat);
    held_out = resp_out;
    held_sel = resp_sel;
    for (int i = 0; i < stall; i++) begin
      check("bp_ready", {31'b0, req_ready}, 32'd0);
      next_cycle();
      check("bp_valid", {31'b0, resp_valid}, 32'd1);
      check("bp_out", {24'b0, resp_out}, {24'b0, held_out});
      check("bp_sel", {29'b0, resp_sel}, {29'b0, held_sel});
    end
    if (stall > 0) resp_ready = 1'b1;
    check("resp_out", {24'b0, resp_out}, {24'b0, exp});
    check("resp_sel", {29'b0, resp_sel}, {29'b0, sel});
`ifdef ALU_FLAGS_EN
    check("resp_zero", {31'b0, resp_zero}, {31'b0, (exp == 8'h00)});
    check("resp_carry", {31'b0, resp_carry},
          {31'b0, (sel == OP_ADD) ? ((int'(a) + int'(b)) > 15) :
                  (sel == OP_SUB) ? (a < b) : 1'b0});
`endif
    $display("[TB] op sel=%0d a=0x%h b=0x%h -> out=0x%h (model 0x%h) lat=%0d stall=%0d",
             sel, a, b, resp_out, exp, cyc - acc_cyc, stall);
    last_hs = cyc;
    next_cycle();
    check("idle_valid", {31'b0, resp_valid}, 32'd0);
    check("idle_ready", {31'b0, req_ready}, 32'd1);
  endtask

  initial begin
    int          n;
    bit          seen;
    bit          chain;
    bit          nchain;
    logic [3:0]  ca, cb, na, nb;
    logic [2:0]  cs, ns;
    int          stall;

    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_sel = '0; resp_ready = 1'b1;
    next_cycle();
    next_cycle();
    check("rst_req_ready", {31'b0, req_ready}, 32'd0);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_resp_out", {24'b0, resp_out}, 32'd0);
    check("rst_resp_sel", {29'b0, resp_sel}, 32'd0);
`ifdef ALU_FLAGS_EN
    check("rst_zero", {31'b0, resp_zero}, 32'd0);
    check("rst_carry", {31'b0, resp_carry}, 32'd0);
`endif
    @(negedge clk); rst = 1'b0; #1;
    check("idle_req_ready", {31'b0, req_ready}, 32'd1);
    $display("[TB] reset released");

    // Opcode sweep a=0xB, b=0x3
    for (int s = 0; s < 8; s++) run_op(4'hB, 4'h3, 3'(s), 0, 1'b0, 1'b0, 4'h0, 4'h0, 3'd0);

    // Wrap / extremes
    run_op(4'h3, 4'hB, OP_SUB, 0, 1'b0, 1'b0, 4'h0, 4'h0, 3'd0);
    run_op(4'hF, 4'hF, OP_MUL, 0, 1'b0, 1'b0, 4'h0, 4'h0, 3'd0);
    run_op(4'hF, 4'h7, OP_SHL, 0, 1'b0, 1'b0, 4'h0, 4'h0, 3'd0);
    run_op(4'h3, 4'hB, OP_LTU, 0, 1'b0, 1'b0, 4'h0, 4'h0, 3'd0);
    run_op(4'h0, 4'h9, OP_MUL, 0, 1'b0, 1'b0, 4'h0, 4'h0, 3'd0);

    // Backpressure with a second request waiting
    run_op(4'h7, 4'h9, OP_ADD, 4, 1'b1, 1'b0, 4'h2, 4'h5, OP_XOR);
    run_op(4'h2, 4'h5, OP_XOR, 0, 1'b0, 1'b1, 4'h0, 4'h0, 3'd0);

    // Back-to-back with req_valid held
    run_op(4'hB, 4'h3, OP_ADD, 0, 1'b1, 1'b0, 4'hB, 4'h3, OP_MUL);
    run_op(4'hB, 4'h3, OP_MUL, 0, 1'b0, 1'b1, 4'h0, 4'h0, 3'd0);

    // Flag cases
    run_op(4'hF, 4'h1, OP_ADD, 0, 1'b0, 1'b0, 4'h0, 4'h0, 3'd0);
    run_op(4'h4, 4'h4, OP_SUB, 0, 1'b0, 1'b0, 4'h0, 4'h0, 3'd0);

    // Reset during MUL aborts the op
    req_valid = 1'b1; req_a = 4'h5; req_b = 4'h6; req_sel = OP_MUL;
    n = 0;
    while (!req_ready && n < 20) begin next_cycle(); n++; end
    check("abort_accept", {31'b0, req_ready}, 32'd1);
    @(negedge clk); req_valid = 1'b0; #1;
    next_cycle();
    rst = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    check("abort_valid", {31'b0, resp_valid}, 32'd0);
    check("abort_ready", {31'b0, req_ready}, 32'd1);
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (resp_valid || resp_out == 8'h1E) seen = 1'b1;
      next_cycle();
    end
    check("abort_noresp", {31'b0, seen}, 32'd0);
    $display("[TB] abort MUL 0x5*0x6 by reset, response seen=%0d", seen);

    // Randomized traffic
    chain = 1'b0; ca = '0; cb = '0; cs = '0;
    for (int i = 0; i < 40; i++) begin
      if (!chain) begin
        ca = 4'($urandom); cb = 4'($urandom); cs = 3'($urandom);
      end
      nchain = ($urandom_range(0, 2) == 0);
      na = 4'($urandom); nb = 4'($urandom); ns = 3'($urandom);
      stall = $urandom_range(0, 2);
      run_op(ca, cb, cs, stall, nchain, chain, na, nb, ns);
      chain = nchain; ca = na; cb = nb; cs = ns;
      if (!chain) begin
        repeat ($urandom_range(0, 2)) begin
          next_cycle();
          check("gap_valid", {31'b0, resp_valid}, 32'd0);
        end
      end
    end
    if (chain) run_op(ca, cb, cs, 0, 1'b0, 1'b1, 4'h0, 4'h0, 3'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_handshake_unit.md
Name: alu_handshake_unit

Overview:
- Synchronous ALU responder. Accepts one operand/opcode request over a valid/ready handshake and returns the widened result over a second valid/ready handshake.
- Executes the same 8-op, 4-bit-in / 8-bit-out operation set as the combinational ALU.
- MUL runs as an iterative shift-add, so the result path has variable latency.
- Sits between a sequencer or CPU stub (initiator) and any result consumer.

Parameters:
- W, 4, operand width; result width is 2*W.
- MUL_ITER, W, shift-add iterations for MUL; fixed equal to W.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request
- req_a  input  W  operand a
- req_b  input  W  operand b
- req_sel  input  3  opcode
- resp_valid  output  1  result present
- resp_ready  input  1  consumer accepts result
- resp_out  output  2W  result
- resp_sel  output  3  opcode echo of the completed request

Behaviour:
- Interface decision: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: req_ready=0 during the rst cycle, then 1 in IDLE; resp_valid=0; resp_out=0; resp_sel=0.
- FSM states:
  - IDLE: req_ready=1. On req_valid, capture a, b, sel. sel==MUL goes to MUL; any other opcode computes the result and goes to RESP.
  - MUL: one shift-add step per cycle; iteration counter runs 0..MUL_ITER-1; after the last step, go to RESP.
  - RESP: resp_valid=1. On resp_ready, go to IDLE. req_ready=0 in MUL and RESP.
- Latency: request handshake in cycle N.
  - Non-MUL opcodes: resp_valid high from cycle N+1.
  - MUL: resp_valid high from cycle N+1+MUL_ITER, i.e. N+5 at default W=4.
- Throughput: at most one op per 2 cycles. A new request is never accepted in the same cycle as the response handshake.
- Backpressure: resp_out and resp_sel are held stable while resp_valid && !resp_ready.
- Request inputs are ignored outside IDLE.
- Opcode arithmetic (operands zero-extended to 2W, results taken mod 2^(2W)):
  - 0 ADD: a+b
  - 1 SUB: a-b, two's-complement wrap; e.g. 3-11 = 0xF8
  - 2 MUL: a*b, unsigned
  - 3 AND, 4 OR, 5 XOR: bitwise, zero-extended
  - 6 SHL: a << b[2:0], truncated to 2W
  - 7 LTU: 1 if a<b unsigned, else 0
- Boundaries:
  - MUL with a zero operand still takes the full MUL_ITER cycles.
  - 0xF*0xF = 0xE1.
  - rst asserted in MUL or RESP aborts the op: next cycle is IDLE, resp_valid=0, the result is discarded, and no response is issued for the aborted request.
  - req_valid held high across a completed op: the next request is accepted on the first IDLE cycle.

Optional Feature:
- Macro: ALU_FLAGS_EN.
- Defined: two extra outputs, resp_zero (1) and resp_carry (1). Both are registered alongside resp_out, reset to 0, and held under backpressure.
  - resp_zero = (resp_out==0).
  - resp_carry = bit W of the ADD sum, or the borrow for SUB (a<b); 0 for all other ops.
- Undefined: the ports do not exist and no flag logic is present.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams: OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_AND=3, OP_OR=4, OP_XOR=5, OP_SHL=6, OP_LTU=7
  - FSM state encoding: IDLE, MUL, RESP
  - default W=4
- One natural sub-module: alu_mul_iter, an iterative unsigned shift-add multiplier.
  - Interface: start, a, b; done, product.
  - Owns the iteration counter and partial-product register.

Test Plan:
- Sweep: a=0xB, b=0x3, sel 0..7, resp_ready=1. Required results: ADD 0x0E, SUB 0x08, MUL 0x21, AND 0x03, OR 0x0B, XOR 0x08, SHL 0x58, LTU 0x00. resp_sel echoes each opcode; non-MUL ops respond at N+1, MUL at N+5.
- Wrap/extremes: SUB 0x3-0xB gives 0xF8; MUL 0xF*0xF gives 0xE1; SHL 0xF<<7 gives 0x80; LTU 0x3<0xB gives 0x01.
- Backpressure: resp_ready=0 for 4 cycles after ADD 0x7+0x9. resp_valid stays 1 with resp_out=0x10 stable; req_ready stays 0; a second request presented meanwhile is accepted only after the handshake.
- Reset mid-MUL: assert rst 2 cycles after accepting MUL 0x5*0x6. Next cycle is IDLE with resp_valid=0, and 0x1E never appears.
- Back-to-back: req_valid held high with ADD then MUL. Accepts occur in cycles 0 and 2; results 0x0E then 0x21 arrive in order.
- With ALU_FLAGS_EN defined: ADD 0xF+0x1 gives resp_out 0x10, carry=1, zero=0. SUB 0x4-0x4 gives 0x00, zero=1, carry=0.
